// File: rtl/vga_pkg.sv
// vga_pkg: shared fetch-state type and default sizing for the VGA frame fetcher
package vga_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, DONE} fetch_state_e;
    localparam int          DEF_ADDR_WIDTH  = 32;
    localparam int          DEF_DATA_WIDTH  = 64;
    localparam int          DEF_PXL_WIDTH   = 16;
    localparam int          DEF_FIFO_DEPTH  = 8;
    localparam int          DEF_FRAME_WORDS = 76800;
    localparam logic [63:0] DEF_BASE_ADDR   = 64'h0;
endpackage

// File: rtl/vga_sync_fifo.sv
// vga_sync_fifo: single-clock word buffer with flush, head word visible on data_o
module vga_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = data_i;
        wr_d    = flush_i ? '0 : wr_q + AW'(do_push);
        rd_d    = flush_i ? '0 : rd_q + AW'(do_pop);
        count_d = flush_i ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/vga_frame_fetch.sv
// vga_frame_fetch: fetches a frame buffer one word at a time into a FIFO
// and serves pixels LSB-first to the pixel generator
module vga_frame_fetch
    import vga_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                    PXL_WIDTH   = DEF_PXL_WIDTH,
    parameter int                    FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = DEF_BASE_ADDR[ADDR_WIDTH-1:0],
    parameter int                    FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start_i,
    output logic                  req_data_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic                  pxl_rd_i,
    output logic [PXL_WIDTH-1:0]  pxl_o,
    output logic                  pxl_valid_o,
    output logic                  underflow_o
);
    localparam int PPW = DATA_WIDTH / PXL_WIDTH;
    localparam int IW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int CW  = $clog2(FRAME_WORDS + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_e          state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [PXL_WIDTH-1:0]  pxl_q, pxl_d;
    logic                  pxl_valid_q, pxl_valid_d, underflow_q, underflow_d;
    logic                  push, pop, rd_ok, credit, full, empty;
    logic [FCW-1:0]        fifo_count;
    logic [DATA_WIDTH-1:0] head;
    vga_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (frame_start_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (data_i),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );
    // req_q is high exactly while the single request is outstanding
    assign credit = ({1'b0, fifo_count} + (FCW+1)'(req_q)) < (FCW+1)'(FIFO_DEPTH);
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            IDLE, FETCH, DONE: begin
                if (frame_start_i) begin
                    state_d = FETCH;
                    req_d   = 1'b0;
                    addr_d  = BASE_ADDR;
                    cnt_d   = '0;
                end else if (state_q == FETCH && credit) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                end
            end
            WAIT: begin
                if (frame_start_i) begin
                    // a word arriving together with the restart is simply dropped
                    state_d = data_valid_i ? FETCH : DRAIN;
                    req_d   = 1'b0;
                    addr_d  = BASE_ADDR;
                    cnt_d   = '0;
                end else if (data_valid_i) begin
                    push    = !full;
                    req_d   = 1'b0;
                    addr_d  = addr_q + ADDR_WIDTH'(DATA_WIDTH / 8);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_d == CW'(FRAME_WORDS)) ? DONE : FETCH;
                end
            end
            DRAIN: if (data_valid_i) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end
    assign rd_ok = pxl_rd_i && !empty;
    assign pop   = rd_ok && idx_q == IW'(PPW - 1);
    always_comb begin
        pxl_d       = rd_ok ? head[int'(idx_q) * PXL_WIDTH +: PXL_WIDTH] : '0;
        pxl_valid_d = rd_ok;
        idx_d       = frame_start_i ? '0 : rd_ok ? (pop ? '0 : idx_q + 1'b1) : idx_q;
        underflow_d = !frame_start_i && (underflow_q || (pxl_rd_i && empty));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= BASE_ADDR;
            cnt_q       <= '0;
            idx_q       <= '0;
            pxl_q       <= '0;
            pxl_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pxl_q       <= pxl_d;
            pxl_valid_q <= pxl_valid_d;
            underflow_q <= underflow_d;
        end
    end
    assign req_data_o  = req_q;
    assign addr_o      = addr_q;
    assign pxl_o       = pxl_q;
    assign pxl_valid_o = pxl_valid_q;
    assign underflow_o = underflow_q;
endmodule

// File: tb/tb_vga_frame_fetch.sv
// tb_vga_frame_fetch: directed scoreboard bench with a latency-programmable memory responder
module tb_vga_frame_fetch;
    import vga_pkg::*;
    localparam int FW = 16;
    logic        clk = 1'b0;
    logic        rst_n, frame_start_i, req_data_o, data_valid_i, pxl_rd_i, pxl_valid_o, underflow_o;
    logic [31:0] addr_o;
    logic [63:0] data_i;
    logic [15:0] pxl_o;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] exp_addr[$];
    logic [15:0] exp_pix[$];
    int          obs_rd = 0;
    logic [15:0] next_pix;
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_left, mem_delay, base;

    vga_frame_fetch #(.FRAME_WORDS(FW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start_i (frame_start_i),
        .req_data_o    (req_data_o),
        .addr_o        (addr_o),
        .data_i        (data_i),
        .data_valid_i  (data_valid_i),
        .pxl_rd_i      (pxl_rd_i),
        .pxl_o         (pxl_o),
        .pxl_valid_o   (pxl_valid_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_at(input logic [31:0] a);
        logic [63:0] r;
        logic [31:0] w;
        w = a >> 3;
        for (int p = 0; p < 4; p++) r[p*16 +: 16] = 16'(w * 4 + 32'(p) + 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        exp_addr.delete();
        for (int i = 0; i < FW; i++) exp_addr.push_back(32'(i * 8));
        exp_pix.delete();
        next_pix = 16'd1;
        frame_start_i = 1'b1;
        @(negedge clk);
        frame_start_i = 1'b0;
    endtask

    task automatic cmp_addrs(input string tag);
        while (obs_rd < obs_addr.size()) begin
            chk(tag, 64'(obs_addr[obs_rd]), exp_addr.size() > 0 ? 64'(exp_addr.pop_front()) : '1);
            obs_rd++;
        end
    endtask

    task automatic wait_reqs(input string tag, input int target);
        int t;
        t = 0;
        while (obs_addr.size() < target && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(tag, 64'(obs_addr.size() >= target), 64'(1));
    endtask

    task automatic pops(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            pxl_rd_i = 1'b1;
            exp_pix.push_back(next_pix);
            next_pix++;
            @(negedge clk);
            pxl_rd_i = 1'b0;
            chk("pxl_valid", 64'(pxl_valid_o), 64'(1));
            chk("pxl_data", 64'(pxl_o), 64'(exp_pix.pop_front()));
            repeat (gap) @(negedge clk);
        end
    endtask

    // memory: answers each new request mem_delay negedges after it is seen
    initial begin
        data_valid_i = 1'b0;
        data_i = '0;
        mem_busy = 1'b0;
        mem_left = 0;
        mem_addr = '0;
        forever begin
            @(negedge clk);
            data_valid_i = 1'b0;
            if (mem_busy) begin
                mem_left--;
                if (mem_left <= 0) begin
                    data_valid_i = 1'b1;
                    data_i = word_at(mem_addr);
                    mem_busy = 1'b0;
                end
            end else if (req_data_o === 1'b1) begin
                mem_busy = 1'b1;
                mem_addr = addr_o;
                mem_left = mem_delay;
                obs_addr.push_back(addr_o);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        frame_start_i = 1'b0;
        pxl_rd_i = 1'b0;
        mem_delay = 2;
        next_pix = 16'd1;
        repeat (2) @(negedge clk);
        chk("rst_req", 64'(req_data_o), 64'(0));
        chk("rst_addr", 64'(addr_o), 64'(0));
        chk("rst_pxl", 64'(pxl_o), 64'(0));
        chk("rst_pxl_valid", 64'(pxl_valid_o), 64'(0));
        chk("rst_underflow", 64'(underflow_o), 64'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_req", 64'(req_data_o), 64'(0));
        chk("idle_state", 64'(dut.state_q), 64'(IDLE));
        // fill: credit limit stops requests at FIFO depth
        start_frame();
        repeat (80) @(negedge clk);
        chk("req_count_fill", 64'(obs_addr.size()), 64'(8));
        cmp_addrs("addr_fill");
        chk("req_stalled", 64'(req_data_o), 64'(0));
        chk("fifo_full", 64'(dut.u_fifo.count_o), 64'(8));
        pops(3, 0);
        chk("count_before_wrap", 64'(dut.u_fifo.count_o), 64'(8));
        pops(1, 0);
        chk("count_after_wrap", 64'(dut.u_fifo.count_o), 64'(7));
        pops(4 * FW - 4, 1);
        repeat (10) @(negedge clk);
        chk("req_count_frame", 64'(obs_addr.size()), 64'(FW));
        cmp_addrs("addr_frame");
        chk("last_addr", 64'(obs_addr[FW-1]), 64'(32'h78));
        chk("done_state", 64'(dut.state_q), 64'(DONE));
        chk("done_req", 64'(req_data_o), 64'(0));
        chk("done_fifo_empty", 64'(dut.u_fifo.count_o), 64'(0));
        chk("no_underflow", 64'(underflow_o), 64'(0));
        // underflow on empty FIFO, sticky until the next frame start
        pxl_rd_i = 1'b1;
        @(negedge clk);
        pxl_rd_i = 1'b0;
        chk("uf_valid", 64'(pxl_valid_o), 64'(0));
        chk("uf_pxl", 64'(pxl_o), 64'(0));
        chk("uf_flag", 64'(underflow_o), 64'(1));
        repeat (3) @(negedge clk);
        chk("uf_sticky", 64'(underflow_o), 64'(1));
        mem_delay = 3;
        base = obs_addr.size();
        start_frame();
        chk("uf_cleared", 64'(underflow_o), 64'(0));
        // restart while a request is outstanding
        wait_reqs("req_a", base + 1);
        wait_reqs("req_b", base + 2);
        cmp_addrs("addr_pre_abort");
        start_frame();
        chk("drain_state", 64'(dut.state_q), 64'(DRAIN));
        chk("drain_flushed", 64'(dut.u_fifo.count_o), 64'(0));
        wait_reqs("req_restart", base + 3);
        chk("restart_fifo_empty", 64'(dut.u_fifo.count_o), 64'(0));
        cmp_addrs("addr_restart");
        // reset in WAIT; the in-flight word lands later in IDLE
        rst_n = 1'b0;
        @(negedge clk);
        chk("wrst_req", 64'(req_data_o), 64'(0));
        chk("wrst_addr", 64'(addr_o), 64'(0));
        chk("wrst_pxl_valid", 64'(pxl_valid_o), 64'(0));
        chk("wrst_state", 64'(dut.state_q), 64'(IDLE));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_req", 64'(req_data_o), 64'(0));
        chk("stray_state", 64'(dut.state_q), 64'(IDLE));
        chk("stray_fifo", 64'(dut.u_fifo.count_o), 64'(0));
        chk("stray_no_new_req", 64'(obs_addr.size()), 64'(base + 3));
        mem_delay = 2;
        start_frame();
        wait_reqs("req_after_rst", base + 4);
        repeat (3) @(negedge clk);
        pops(4, 0);
        cmp_addrs("addr_after_rst");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_frame_fetch.md
VGA_FRAME_FETCH -- requirements
Module: vga_frame_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning fetched word width.
REQ-003 SHALL have parameter PXL_WIDTH, default 16, meaning pixel width; DATA_WIDTH/PXL_WIDTH (PPW, default 4) pixels per word.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning word buffer depth (power of 2).
REQ-005 SHALL have parameter BASE_ADDR, default 0, meaning frame buffer byte address.
REQ-006 SHALL have parameter FRAME_WORDS, default 76800, meaning words per frame (640x480/4).
REQ-007 SHALL have port clk  in  1  clock.
REQ-008 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-009 SHALL have port frame_start_i  in  1  one-cycle pulse at frame start.
REQ-010 SHALL have port req_data_o  out  1  word request to AXI-Lite master.
REQ-011 SHALL have port addr_o  out  ADDR_WIDTH  byte address of requested word.
REQ-012 SHALL have port data_i  in  DATA_WIDTH  returned read data.
REQ-013 SHALL have port data_valid_i  in  1  data_i valid, one cycle per request.
REQ-014 SHALL have port pxl_rd_i  in  1  pixel pop from pixel generator.
REQ-015 SHALL have port pxl_o  out  PXL_WIDTH  popped pixel, registered.
REQ-016 SHALL have port pxl_valid_o  out  1  pxl_o holds real data this cycle.
REQ-017 SHALL have port underflow_o  out  1  sticky underflow flag.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, WAIT, DRAIN, DONE.
REQ-019 IDLE: on frame_start_i, clear word counter, set addr_o=BASE_ADDR, go FETCH.
REQ-020 FETCH: when fifo_count + outstanding < FIFO_DEPTH, assert req_data_o with addr_o stable; go WAIT.
REQ-021 WAIT: hold req_data_o and addr_o until data_valid_i; then push data_i, addr_o += DATA_WIDTH/8, word counter++.
REQ-022 WAIT exit: counter==FRAME_WORDS -> DONE, else FETCH; at most one outstanding request at any time.
REQ-023 DONE: req_data_o=0; on frame_start_i restart as in REQ-019.
REQ-024 frame_start_i in FETCH/DONE: flush FIFO and pixel index same cycle, restart per REQ-019.
REQ-025 frame_start_i in WAIT: flush FIFO, go DRAIN; DRAIN discards the next data_valid_i word, then restart per REQ-019.
REQ-026 Pixel pop: pxl_rd_i with FIFO non-empty -> next cycle pxl_o = head word bits [idx*PXL_WIDTH +: PXL_WIDTH], idx from 0 (LSB first), pxl_valid_o=1.
REQ-027 idx wraps PPW-1 -> 0 and pops FIFO head on same cycle.
REQ-028 pxl_rd_i with FIFO empty: next cycle pxl_o=0, pxl_valid_o=0, underflow_o=1.
REQ-029 underflow_o SHALL stay set until next frame_start_i.
REQ-030 Simultaneous push and pop SHALL keep count constant; push when full is impossible by REQ-020 credit rule.
REQ-031 Address SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-032 On rst_n low: state IDLE, req_data_o=0, addr_o=BASE_ADDR, FIFO empty, idx=0, pxl_o=0, pxl_valid_o=0, underflow_o=0.
REQ-033 Reset mid-request SHALL abandon the request; late data_valid_i after reset release in IDLE SHALL be ignored.

Structure
REQ-034 Package vga_pkg SHALL hold fetch state enum, default widths, FRAME_WORDS and BASE_ADDR constants.
REQ-035 Word buffer SHALL be sub-module vga_sync_fifo (push, pop, full, empty, count).

Verification
REQ-036 Reset release, frame_start, memory answers 2 cycles after each req -> addr_o 0x0,0x8,0x10...; 8 requests before first pxl_rd_i, then req stops.
REQ-037 Word 0x0004_0003_0002_0001 then 4 pxl_rd_i -> pxl_o 0x0001,0x0002,0x0003,0x0004, FIFO count drops by 1 after 4th.
REQ-038 FRAME_WORDS=16, continuous pops -> exactly 16 requests, last addr 0x78, state DONE, req_data_o=0.
REQ-039 pxl_rd_i with FIFO empty -> pxl_valid_o=0, pxl_o=0, underflow_o=1 until next frame_start_i.
REQ-040 frame_start_i during WAIT, data returns 3 cycles later -> word discarded, next req addr_o=BASE_ADDR, FIFO empty.
REQ-041 rst_n low during WAIT -> all outputs reset values next edge; stray data_valid_i ignored.
